twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/twiddle_pkg.sv | 51 +++++
 rtl/twiddle_qrom.sv | 41 ++++
 rtl/twiddle_gen.sv | 180 ++++++++++++++++++
 tb/tb_twiddle_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared definitions for the FFT twiddle generator: FSM state type,
// default size constants and the elaboration-time cosine table function.
package twiddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Sizes for the default build (LOG2N = 4).
  localparam int LOG2N_DEF = 4;
  localparam int N         = 1 << LOG2N_DEF;
  localparam int HALF_N    = N / 2;
  localparam int QTR_N     = N / 4;

  localparam real PI = 3.14159265358979323846;

  // Number of quarter-wave steps for an FFT of length 2**log2n.
  function automatic int qtr_n(input int log2n);
    return 1 << (log2n - 2);
  endfunction

  // C[i] = round(cos(2*pi*i/N) * 2**(width-1)), saturated to the largest
  // positive code. Evaluated with a Taylor series so only basic real
  // arithmetic is needed when the table is folded at elaboration.
  function automatic int cos_q(input int i, input int width, input int log2n);
    real x;
    real x2;
    real term;
    real sum;
    real full;
    int  r;
    int  max_code;
    x        = 2.0 * PI * real'(i) / real'(1 << log2n);
    x2       = x * x;
    term     = 1.0;
    sum      = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x2 / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    full     = real'(longint'(1) << (width - 1));
    max_code = int'((longint'(1) << (width - 1)) - 1);
    r        = $rtoi(sum * full + 0.5);
    if (r > max_code) r = max_code;
    if (r < 0)        r = 0;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM: QTR_N+1 constant entries, two registered read
// ports (cosine index and complement index) sharing one enable.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [LOG2N-2:0]        addr_c,
  input  logic [LOG2N-2:0]        addr_s,
  output logic signed [WIDTH-1:0] rd_c,
  output logic signed [WIDTH-1:0] rd_s
);

  localparam int QN = qtr_n(LOG2N);

  // NOTE: the table is constant wiring, so it has no reset; only the read
  // registers below carry state that reset must clear.
  logic signed [WIDTH-1:0] tbl [QN+1];

  for (genvar g = 0; g <= QN; g++) begin : g_tbl
    assign tbl[g] = WIDTH'(cos_q(g, WIDTH, LOG2N));
  end

  // Registered reads, advancing only with the pipeline.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_c <= '0;
      rd_s <= '0;
    end else if (en) begin
      rd_c <= tbl[addr_c];
      rd_s <= tbl[addr_s];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 DIT twiddle-factor sequencer. One start produces the N/2 twiddles
// of a stage through a three-deep pipeline (issue -> ROM read -> output)
// with valid/ready backpressure.
// Optional build macro TWIDDLE_INV_EN adds the 'inv' port for conjugate
// (inverse FFT) twiddles.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(LOG2N)-1:0]   stage,
`ifdef TWIDDLE_INV_EN
  input  logic                       inv,
`endif
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       out_valid,
  output logic signed [WIDTH-1:0]    wr,
  output logic signed [WIDTH-1:0]    wi,
  output logic [LOG2N-2:0]           k,
  output logic                       last
);

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int HN = 1 << (LOG2N - 1);
  localparam int QN = qtr_n(LOG2N);

  localparam logic [KW-1:0] J_LAST = KW'(HN - 1);
  localparam logic [KW-1:0] K_QTR  = KW'(QN);
  localparam logic [SW-1:0] S_TOP  = SW'(LOG2N - 1);

  state_t state, state_nxt;

  logic          adv;
  logic          accept;
  logic          issue;
  logic [KW-1:0] j_q;
  logic [SW-1:0] s_q;
  logic [KW-1:0] j_mask;
  logic [KW-1:0] k_issue;

  // Issue stage
  logic          v0, l0;
  logic [KW-1:0] k0;
  // ROM read stage
  logic          v1, l1, hi1;
  logic [KW-1:0] k1;
  logic          k0_hi;
  logic [KW-1:0] k_off;
  logic [KW-1:0] addr_c, addr_s;
  logic signed [WIDTH-1:0] rd_c, rd_s;

`ifdef TWIDDLE_INV_EN
  logic inv_q;
`endif

  // The whole pipeline moves together unless a valid word is being held.
  assign adv    = !out_valid || out_ready;
  assign accept = (state == ST_IDLE) && start && (int'(stage) < LOG2N);
  assign issue  = (state == ST_RUN) && adv;
  assign busy   = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: defaulting state_nxt before the case keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)                         state_nxt = ST_RUN;
      ST_RUN:   if (issue && (j_q == J_LAST))       state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready && last) state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // k = (j mod 2**s) << (LOG2N-1-s); a full-width mask covers s = LOG2N-1.
  always_comb begin
    j_mask  = (KW'(1) << s_q) - KW'(1);
    k_issue = (j_q & j_mask) << (S_TOP - s_q);
  end

  // Issue stage: latch request on start, then step j once per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= '0;
      s_q <= '0;
      v0  <= 1'b0;
      k0  <= '0;
      l0  <= 1'b0;
    end else begin
      if (accept) begin
        s_q <= stage;
        j_q <= '0;
      end
      if (adv) begin
        v0 <= issue;
        k0 <= k_issue;
        l0 <= issue && (j_q == J_LAST);
        if (issue) j_q <= j_q + KW'(1);
      end
    end
  end

`ifdef TWIDDLE_INV_EN
  // Direction of the sequence is fixed at start time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`endif

  // Quadrant folding: second quadrant reads the table mirrored.
  always_comb begin
    k0_hi  = (k0 >= K_QTR);
    k_off  = k0 - K_QTR;
    addr_c = k0_hi ? (K_QTR - k_off) : k0;
    addr_s = k0_hi ? k_off : (K_QTR - k0);
  end

  twiddle_qrom #(
    .WIDTH (WIDTH),
    .LOG2N (LOG2N)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .addr_c (addr_c),
    .addr_s (addr_s),
    .rd_c   (rd_c),
    .rd_s   (rd_s)
  );

  // ROM read stage: carry control alongside the table read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      k1  <= '0;
      l1  <= 1'b0;
      hi1 <= 1'b0;
    end else if (adv) begin
      v1  <= v0;
      k1  <= k0;
      l1  <= l0;
      hi1 <= k0_hi;
    end
  end

  // Output stage: apply quadrant and direction signs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      k         <= '0;
      last      <= 1'b0;
      wr        <= '0;
      wi        <= '0;
    end else if (adv) begin
      out_valid <= v1;
      k         <= k1;
      last      <= l1;
      wr        <= hi1 ? -rd_c : rd_c;
`ifdef TWIDDLE_INV_EN
      wi        <= inv_q ? rd_s : -rd_s;
`else
      wi        <= -rd_s;
`endif
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen (N=16, WIDTH=16). Stimulus pushes the
// expected words; a negedge monitor pops and compares on each transfer.
module tb_twiddle_gen;

  typedef struct {
    int wr;
    int wi;
    int k;
    int last;
  } word_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         stage = 2'd0;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               out_valid;
  logic signed [15:0] wr;
  logic signed [15:0] wi;
  logic [2:0]         k;
  logic               last;
`ifdef TWIDDLE_INV_EN
  logic               inv = 1'b0;
`endif

  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    n_xfer = 0;
  int    bp_cnt = 0;
  bit    bp_en  = 1'b0;
  bit    stall_prev = 1'b0;
  bit    busy_fall_pend = 1'b0;
  word_t sb[$];
  word_t held;
  word_t e;

  // cos(2*pi*k/16) and -sin(2*pi*k/16) in Q1.15, k = 0..7.
  int wr_tab[8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
  int wi_tab[8] = '{0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};

  always #5 clk = ~clk;

  twiddle_gen #(
    .WIDTH (16),
    .LOG2N (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stage     (stage),
`ifdef TWIDDLE_INV_EN
    .inv       (inv),
`endif
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .wr        (wr),
    .wi        (wi),
    .k         (k),
    .last      (last)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seq(input int s, input bit conj);
    for (int j = 0; j < 8; j++) begin
      word_t w;
      int    kk;
      kk     = (j % (1 << s)) << (3 - s);
      w.k    = kk;
      w.wr   = wr_tab[kk];
      w.wi   = conj ? -wi_tab[kk] : wi_tab[kk];
      w.last = (j == 7) ? 1 : 0;
      sb.push_back(w);
    end
  endtask

  task automatic pulse_start(input int s);
    start = 1'b1;
    stage = 2'(s);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_queue_end"}, sb.size(), 0);
  endtask

  // Backpressure pattern 1,0,0,1 repeating, one value per cycle.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
      bp_cnt++;
    end
  end

  // Monitor: compare each transferred word, check stall stability and busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev     = 1'b0;
      busy_fall_pend = 1'b0;
    end else begin
      if (busy_fall_pend) begin
        check("busy_after_last", int'(busy), 0);
        busy_fall_pend = 1'b0;
      end
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_wr", int'(wr), held.wr);
        check("stall_wi", int'(wi), held.wi);
        check("stall_k", int'(k), held.k);
        check("stall_last", int'(last), held.last);
      end
      if (out_valid && out_ready) begin
        check("word_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr", int'(wr), e.wr);
          check("wi", int'(wi), e.wi);
          check("k", int'(k), e.k);
          check("last", int'(last), e.last);
        end
        check("busy_at_xfer", int'(busy), 1);
        if (last) busy_fall_pend = 1'b1;
        n_xfer++;
      end
      stall_prev = out_valid && !out_ready;
      held.wr    = int'(wr);
      held.wi    = int'(wi);
      held.k     = int'(k);
      held.last  = int'(last);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr", int'(wr), 0);
    check("rst_wi", int'(wi), 0);
    check("rst_k", int'(k), 0);
    check("rst_last", int'(last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // s=3 with latency: first out_valid three edges after the start edge.
    push_seq(3, 1'b0);
    pulse_start(3);
    check("lat_busy", int'(busy), 1);
    check("lat_valid_e0", int'(out_valid), 0);
    @(posedge clk);
    #1 check("lat_valid_e1", int'(out_valid), 0);
    @(posedge clk);
    #1 check("lat_valid_e2", int'(out_valid), 0);
    @(posedge clk);
    #1 check("lat_valid_e3", int'(out_valid), 1);
    wait_done("s3", 40);

    // s=0 and s=1.
    push_seq(0, 1'b0);
    pulse_start(0);
    wait_done("s0", 40);
    push_seq(1, 1'b0);
    pulse_start(1);
    wait_done("s1", 40);

    // Backpressure during s=3.
    bp_cnt = 0;
    bp_en  = 1'b1;
    push_seq(3, 1'b0);
    pulse_start(3);
    wait_done("bp", 120);
    bp_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    // Second start while busy is ignored. A 2-bit stage field cannot encode
    // values >= LOG2N at this size, so only the busy case can be driven.
    n0 = n_xfer;
    push_seq(1, 1'b0);
    pulse_start(1);
    repeat (2) @(posedge clk);
    #1 check("busy_before_restart", int'(busy), 1);
    pulse_start(2);
    wait_done("ignored", 40);
    repeat (10) @(posedge clk);
    #1;
    check("ignored_no_valid", int'(out_valid), 0);
    check("ignored_busy", int'(busy), 0);
    check("ignored_count", n_xfer - n0, 8);

    // Asynchronous reset while the 4th word is presented.
    n0 = n_xfer;
    push_seq(3, 1'b0);
    pulse_start(3);
    n = 0;
    while (n_xfer < n0 + 3 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_reached", n_xfer - n0, 3);
    check("rst_mid_4th_valid", int'(out_valid), 1);
    check("rst_mid_4th_k", int'(k), 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_wr", int'(wr), 0);
    check("arst_wi", int'(wi), 0);
    check("arst_k", int'(k), 0);
    check("arst_last", int'(last), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle_valid", int'(out_valid), 0);
    check("post_rst_idle_busy", int'(busy), 0);
    push_seq(2, 1'b0);
    pulse_start(2);
    wait_done("s2_after_rst", 40);

`ifdef TWIDDLE_INV_EN
    // Conjugate twiddles.
    inv = 1'b1;
    push_seq(3, 1'b1);
    pulse_start(3);
    inv = 1'b0;
    wait_done("inv", 40);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
